key_event_arbiter: RTL and testbench
====================================

# key_event_arbiter

Debounces a bank of raw active-low push-buttons and turns each press into a single key-ID event on a valid/ready stream. A shared sampling-tick divider schedules debounce updates for all keys. A round-robin arbiter shares the one event output between keys, and per-key pending flags absorb backpressure. The block sits between the board key pins and the mode/control logic of the experiment top level.

## Interface
- NUM_KEYS, 4: number of keys, 2..16.
- TICK_DIV, 50000: clk cycles per debounce sample tick, ≥2.
- DEBOUNCE_SAMPLES, 4: consecutive differing samples needed to flip a debounced level, ≥1.
- ID_W (localparam) = max(1, clog2(NUM_KEYS)).
- clk, input, 1: single clock; all logic rises on posedge.
- rst, input, 1: reset, asynchronous, active-high.
- key_in, input, NUM_KEYS: raw key pins, asynchronous, 0 = pressed.
- key_state, output, NUM_KEYS: debounced level, 1 = pressed.
- evt_valid, output, 1: event present.
- evt_id, output, ID_W: index of the pressed key.
- evt_ready, input, 1: consumer accepts the event.
- evt_overrun, output, 1: one-cycle pulse when a press is lost.

## Operation
- Synchronizer: 2-FF chain per key, reset to 1 (released).
- Tick: counter runs 0..TICK_DIV-1 and wraps; tick = (counter == TICK_DIV-1), one cycle wide.
- Debounce, per key, updated only on tick:
  - Compare the synced sample (inverted, so 1 = pressed) against key_state[i].
  - If equal, clear the count.
  - If different and count+1 == DEBOUNCE_SAMPLES, toggle key_state[i] and clear the count.
  - Otherwise increment the count.
  - Count width = clog2(DEBOUNCE_SAMPLES+1).
- Press event: key_state[i] goes 0→1 (registered compare of old and new state). Releases produce no event.
- pending[i]:
  - Set by a press event.
  - Cleared when key i is loaded into the output register.
  - Set and clear in the same cycle: set wins.
- evt_overrun: pulses in the cycle a press event hits a key whose pending is already 1 and is not being cleared that cycle. The event is dropped.
- Arbiter FSM:
  - IDLE: if any pending, choose the first pending index scanning ptr+1, ptr+2, … modulo NUM_KEYS. Load evt_id, set evt_valid, clear that pending bit, set ptr = chosen index, go to SEND.
  - SEND: evt_valid=1; evt_id is held stable.
    - evt_ready=1: evt_valid drops next cycle, go to IDLE.
    - evt_ready=0: hold in SEND indefinitely.
  - evt_valid never drops without a handshake.

## Timing
- Reset values, applied asynchronously and immediately:
  - Outputs: key_state=0, evt_valid=0, evt_id=0, evt_overrun=0.
  - Internals: tick counter=0, debounce counts=0, sync FFs=1, pending=0, FSM=IDLE, ptr=NUM_KEYS-1 (so key 0 has first priority).
- Reset mid-SEND discards the event in flight and all pending presses.
- Pin-to-state latency: 2 sync cycles, plus the wait until the first tick, plus (DEBOUNCE_SAMPLES-1) further ticks.
- Pipeline after key_state rises:
  - Cycle +1: press event registered and pending set.
  - Cycle +2: evt_valid=1, provided the FSM is in IDLE.
- Throughput: at most one event per 2 cycles, because of the mandatory IDLE cycle after each handshake.
- Multiple keys flipping on the same tick each set their own pending bit; nothing is lost.

## Test plan
(NUM_KEYS=4, TICK_DIV=4, DEBOUNCE_SAMPLES=3, evt_ready=1 unless stated.)
- **Clean press:** drive key_in[2]=0 and hold it. Expect key_state[2]=1 within 2+4+8 cycles, then evt_valid=1 with evt_id=2 for exactly one cycle. Release: key_state[2]=0 and no event.
- **Bounce:** key_in[1] low for 2 ticks, then high. Expect key_state=0, evt_valid never asserted, evt_overrun=0.
- **Round robin:** press key 1 alone and expect id 1. Then press keys 0 and 2 on the same tick. Expect id 2, then id 0, with evt_valid separated by one low cycle.
- **Backpressure and overrun:** evt_ready=0; do three debounced press/release cycles on key 0.
  - evt_id=0 and evt_valid=1 stay stable throughout.
  - evt_overrun pulses exactly once, on the third press.
  - Then set evt_ready=1: expect two handshakes with id 0, then evt_valid=0.
- **Simultaneous set/clear:** arrange a key 3 press event in the same cycle its pending bit is loaded. Expect pending to stay set, a second id 3 event after the first handshake, and no overrun.
- **Reset mid-operation:** assert rst while evt_valid=1 and pending≠0. Expect all outputs 0 in the same cycle. After release, no stale events appear and the first press of key 0 yields id 0.

Source files
------------

// File: rtl/key_event_arbiter_if.sv
// Key-pin and key-event bundle between the board buttons, the arbiter and the consumer.
// master = arbiter side, slave = pin driver / event consumer side.
interface key_event_arbiter_if #(
  parameter int NUM_KEYS = 4,
  parameter int ID_W     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
);
  logic [NUM_KEYS-1:0] key_in;
  logic [NUM_KEYS-1:0] key_state;
  logic                evt_valid;
  logic [ID_W-1:0]     evt_id;
  logic                evt_ready;
  logic                evt_overrun;

  modport master (
    input  key_in, evt_ready,
    output key_state, evt_valid, evt_id, evt_overrun
  );

  modport slave (
    output key_in, evt_ready,
    input  key_state, evt_valid, evt_id, evt_overrun
  );
endinterface

// File: rtl/key_event_arbiter.sv
// Debounces active-low push-buttons and emits one key-ID event per press on a
// valid/ready stream, sharing the output between keys round-robin.
module key_event_arbiter #(
  parameter int NUM_KEYS         = 4,
  parameter int TICK_DIV         = 50000,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input logic                  clk,
  input logic                  rst,
  key_event_arbiter_if.master  bus
);
  localparam int ID_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int TCW  = $clog2(TICK_DIV);
  localparam int CW   = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(DEBOUNCE_SAMPLES - 1);

  // state  | meaning
  // S_IDLE | no event on the output; picks the next pending key
  // S_SEND | evt_valid high, evt_id held until evt_ready
  typedef enum logic {S_IDLE, S_SEND} state_t;

  logic [NUM_KEYS-1:0] r_sync1, r_sync2;
  logic [TCW-1:0]      r_tick_cnt;
  logic                w_tick;
  logic [CW-1:0]       r_db_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] r_key_state, r_key_state_d;
  logic [NUM_KEYS-1:0] w_pressed, w_press, w_clear, r_pending;
  logic                r_overrun;
  state_t              r_state;
  logic                r_evt_valid;
  logic [ID_W-1:0]     r_evt_id, r_ptr;
  logic [ID_W-1:0]     w_pick;
  logic                w_found, w_load;
  int                  w_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= bus.key_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  assign w_pressed = ~r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++) r_db_cnt[i] <= '0;
      r_key_state <= '0;
    end else if (w_tick) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (w_pressed[i] == r_key_state[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == CNT_LAST) begin
          r_key_state[i] <= ~r_key_state[i];
          r_db_cnt[i]    <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_press = r_key_state & ~r_key_state_d;

  // Round-robin scan starting just after the last granted key.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int k = 1; k <= NUM_KEYS; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NUM_KEYS) w_idx = w_idx - NUM_KEYS;
      if (!w_found && r_pending[ID_W'(w_idx)]) begin
        w_found = 1'b1;
        w_pick  = ID_W'(w_idx);
      end
    end
  end

  assign w_load  = (r_state == S_IDLE) && w_found;
  assign w_clear = w_load ? ({{(NUM_KEYS-1){1'b0}}, 1'b1} << w_pick) : '0;

  // A press landing on a key whose pending bit is being loaded re-arms it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_state_d <= '0;
      r_pending     <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_key_state_d <= r_key_state;
      r_pending     <= (r_pending & ~w_clear) | w_press;
      r_overrun     <= |(w_press & r_pending & ~w_clear);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_evt_valid <= 1'b0;
      r_evt_id    <= '0;
      r_ptr       <= ID_W'(NUM_KEYS - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_evt_id    <= w_pick;
            r_evt_valid <= 1'b1;
            r_ptr       <= w_pick;
            r_state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (bus.evt_ready) begin
            r_evt_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.key_state   = r_key_state;
  assign bus.evt_valid   = r_evt_valid;
  assign bus.evt_id      = r_evt_id;
  assign bus.evt_overrun = r_overrun;
endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter: debounce, round-robin, backpressure,
// overrun, set/clear collision and reset mid-operation.
module tb_key_event_arbiter;
  localparam int NK  = 4;
  localparam int TD  = 4;
  localparam int DS  = 3;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  key_event_arbiter_if #(.NUM_KEYS(NK)) bus ();

  key_event_arbiter #(
    .NUM_KEYS(NK), .TICK_DIV(TD), .DEBOUNCE_SAMPLES(DS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  logic [IDW-1:0] hs_ids[$];
  int             ovr_cnt      = 0;
  int             valid_cycles = 0;
  int             proto_err    = 0;
  logic           prev_valid   = 1'b0;
  logic           prev_ready   = 1'b0;
  logic [IDW-1:0] prev_id      = '0;

  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.evt_valid) valid_cycles++;
      if (bus.evt_valid && bus.evt_ready) hs_ids.push_back(bus.evt_id);
      if (bus.evt_overrun) ovr_cnt++;
      if (prev_valid && !prev_ready && (!bus.evt_valid || bus.evt_id != prev_id)) proto_err++;
      prev_valid = bus.evt_valid;
      prev_ready = bus.evt_ready;
      prev_id    = bus.evt_id;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hs_id(input int i);
    if (i < hs_ids.size()) return 32'(hs_ids[i]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic set_key(input int k, input logic v);
    @(negedge clk);
    bus.key_in[k] = v;
  endtask

  task automatic wait_state(input int k, input logic v, input int budget, input string tag);
    int n = 0;
    while (bus.key_state[k] !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.key_state[k]), 32'(v));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, t1, e;
    bus.key_in    = '1;
    bus.evt_ready = 1'b1;

    // Reset values
    #1 rst = 1'b1;
    #1;
    check("rst_key_state", 32'(bus.key_state), 32'h0);
    check("rst_valid",     32'(bus.evt_valid), 32'h0);
    check("rst_id",        32'(bus.evt_id), 32'h0);
    check("rst_overrun",   32'(bus.evt_overrun), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Clean press of key 2
    hs_ids.delete();
    set_key(2, 1'b0);
    wait_state(2, 1'b1, 14, "t1_state_rise");
    @(negedge clk); check("t1_valid_p1", 32'(bus.evt_valid), 32'h0);
    @(negedge clk); check("t1_valid_p2", 32'(bus.evt_valid), 32'h1);
                    check("t1_id",       32'(bus.evt_id), 32'h2);
    @(negedge clk); check("t1_valid_p3", 32'(bus.evt_valid), 32'h0);
    set_key(2, 1'b1);
    wait_state(2, 1'b0, 20, "t1_state_fall");
    repeat (6) @(negedge clk);
    check("t1_hs_count", 32'(hs_ids.size()), 32'd1);
    check("t1_hs_id0",   hs_id(0), 32'h2);

    // Bounce on key 1: only two low samples
    hs_ids.delete();
    valid_cycles = 0;
    ovr_cnt = 0;
    set_key(1, 1'b0);
    repeat (8) @(negedge clk);
    bus.key_in[1] = 1'b1;
    repeat (20) @(negedge clk);
    check("t2_key_state", 32'(bus.key_state), 32'h0);
    check("t2_valid_cyc", 32'(valid_cycles), 32'd0);
    check("t2_overrun",   32'(ovr_cnt), 32'd0);

    // Round robin
    hs_ids.delete();
    set_key(1, 1'b0);
    wait_state(1, 1'b1, 20, "t3_k1_rise");
    repeat (3) @(negedge clk);
    check("t3_k1_count", 32'(hs_ids.size()), 32'd1);
    check("t3_k1_id",    hs_id(0), 32'h1);
    set_key(1, 1'b1);
    wait_state(1, 1'b0, 20, "t3_k1_fall");
    repeat (4) @(negedge clk);
    hs_ids.delete();
    @(negedge clk);
    bus.key_in[0] = 1'b0;
    bus.key_in[2] = 1'b0;
    wait_state(0, 1'b1, 20, "t3_k0_rise");
    check("t3_same_tick", 32'(bus.key_state), 32'h5);
    @(negedge clk); check("t3_v_e1", 32'(bus.evt_valid), 32'h0);
    @(negedge clk); check("t3_v_e2", 32'(bus.evt_valid), 32'h1);
                    check("t3_id_e2", 32'(bus.evt_id), 32'h2);
    @(negedge clk); check("t3_v_e3", 32'(bus.evt_valid), 32'h0);
    @(negedge clk); check("t3_v_e4", 32'(bus.evt_valid), 32'h1);
                    check("t3_id_e4", 32'(bus.evt_id), 32'h0);
    @(negedge clk); check("t3_v_e5", 32'(bus.evt_valid), 32'h0);
    @(negedge clk);
    bus.key_in[0] = 1'b1;
    bus.key_in[2] = 1'b1;
    wait_state(0, 1'b0, 20, "t3_k0_fall");
    check("t3_k2_fall",  32'(bus.key_state[2]), 32'h0);
    check("t3_hs_count", 32'(hs_ids.size()), 32'd2);

    // Backpressure and overrun on key 0
    hs_ids.delete();
    ovr_cnt = 0;
    @(negedge clk);
    bus.evt_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      set_key(0, 1'b0);
      wait_state(0, 1'b1, 20, "t4_rise");
      repeat (3) @(negedge clk);
      check("t4_overrun_cnt", 32'(ovr_cnt), (p == 2) ? 32'd1 : 32'd0);
      check("t4_valid_held",  32'(bus.evt_valid), 32'h1);
      check("t4_id_held",     32'(bus.evt_id), 32'h0);
      set_key(0, 1'b1);
      wait_state(0, 1'b0, 20, "t4_fall");
      repeat (2) @(negedge clk);
    end
    check("t4_no_hs", 32'(hs_ids.size()), 32'd0);
    @(negedge clk);
    bus.evt_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("t4_hs_count", 32'(hs_ids.size()), 32'd2);
    check("t4_hs_id0",   hs_id(0), 32'h0);
    check("t4_hs_id1",   hs_id(1), 32'h0);
    check("t4_valid_end", 32'(bus.evt_valid), 32'h0);
    check("t4_overrun_total", 32'(ovr_cnt), 32'd1);

    // Press event of key 3 in the same cycle its pending bit is loaded
    hs_ids.delete();
    ovr_cnt = 0;
    @(negedge clk);
    bus.evt_ready = 1'b0;
    set_key(0, 1'b0);
    wait_state(0, 1'b1, 20, "t5_k0_rise");
    repeat (3) @(negedge clk);
    check("t5_send_id0", 32'(bus.evt_id), 32'h0);
    set_key(0, 1'b1);
    wait_state(0, 1'b0, 20, "t5_k0_fall");
    set_key(3, 1'b0);
    wait_state(3, 1'b1, 20, "t5_k3_rise1");
    set_key(3, 1'b1);
    wait_state(3, 1'b0, 20, "t5_k3_fall1");
    repeat (8) @(negedge clk);
    @(negedge clk);
    bus.key_in[3] = 1'b0;
    c  = cyc;
    t1 = c + 3;
    while (t1 % TD != 0) t1++;
    e  = t1 + (DS - 1) * TD;
    while (cyc < e - 1) @(negedge clk);
    bus.evt_ready = 1'b1;
    @(negedge clk); check("t5_k3_rise2", 32'(bus.key_state[3]), 32'h1);
                    check("t5_v_e0",     32'(bus.evt_valid), 32'h0);
    @(negedge clk); check("t5_v_e1",  32'(bus.evt_valid), 32'h1);
                    check("t5_id_e1", 32'(bus.evt_id), 32'h3);
    @(negedge clk); check("t5_v_e2",  32'(bus.evt_valid), 32'h0);
    @(negedge clk); check("t5_v_e3",  32'(bus.evt_valid), 32'h1);
                    check("t5_id_e3", 32'(bus.evt_id), 32'h3);
    @(negedge clk); check("t5_v_e4",  32'(bus.evt_valid), 32'h0);
    repeat (4) @(negedge clk);
    check("t5_hs_count", 32'(hs_ids.size()), 32'd3);
    check("t5_hs_id0",   hs_id(0), 32'h0);
    check("t5_hs_id1",   hs_id(1), 32'h3);
    check("t5_hs_id2",   hs_id(2), 32'h3);
    check("t5_overrun",  32'(ovr_cnt), 32'd0);
    set_key(3, 1'b1);
    wait_state(3, 1'b0, 20, "t5_k3_fall2");

    // Reset while an event is in flight and another press is pending
    @(negedge clk);
    bus.evt_ready = 1'b0;
    set_key(1, 1'b0);
    wait_state(1, 1'b1, 20, "t6_k1_rise");
    repeat (3) @(negedge clk);
    check("t6_valid_pre", 32'(bus.evt_valid), 32'h1);
    check("t6_id_pre",    32'(bus.evt_id), 32'h1);
    set_key(2, 1'b0);
    wait_state(2, 1'b1, 20, "t6_k2_rise");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.key_in = '1;
    #1;
    check("t6_rst_key_state", 32'(bus.key_state), 32'h0);
    check("t6_rst_valid",     32'(bus.evt_valid), 32'h0);
    check("t6_rst_id",        32'(bus.evt_id), 32'h0);
    check("t6_rst_overrun",   32'(bus.evt_overrun), 32'h0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    hs_ids.delete();
    bus.evt_ready = 1'b1;
    repeat (30) @(negedge clk);
    check("t6_no_stale", 32'(hs_ids.size()), 32'd0);
    check("t6_valid_idle", 32'(bus.evt_valid), 32'h0);
    set_key(0, 1'b0);
    wait_state(0, 1'b1, 20, "t6_k0_rise");
    repeat (4) @(negedge clk);
    check("t6_hs_count", 32'(hs_ids.size()), 32'd1);
    check("t6_hs_id0",   hs_id(0), 32'h0);
    set_key(0, 1'b1);
    wait_state(0, 1'b0, 20, "t6_k0_fall");

    check("protocol_hold", 32'(proto_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
